serial_borrow_subtractor: RTL and testbench

//  Bit-serial ripple-borrow subtractor, the inverse of the ripple carry adder:

---
 rtl/serial_borrow_subtractor.sv | 165 ++++++++++++++++
 tb/tb_serial_borrow_subtractor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_borrow_subtractor.sv
// ---------------------------------------------------------------------------
// serial_borrow_subtractor
//   Bit-serial ripple-borrow subtractor: DiffOut = InputA - InputB - InputBorrow,
//   one bit per clock, LSB first, using one full-subtractor cell and one
//   borrow flop. Result appears WIDTH cycles after the accepting edge.
//
// Optional feature macro: SUB_OVERFLOW_EN (adds the Overflow output).
//
// Ports
//   Clock        in   1      rising-edge clock
//   ResetN       in   1      asynchronous active-low reset
//   Start        in   1      request, honoured only in IDLE or DONE
//   InputA       in   WIDTH  minuend, captured on accept
//   InputB       in   WIDTH  subtrahend, captured on accept
//   InputBorrow  in   1      borrow-in, captured on accept
//   Busy         out  1      high while bits are being processed
//   Done         out  1      one-cycle result-valid pulse
//   DiffOut      out  WIDTH  difference, held until the next completion
//   BorrowOut    out  1      final borrow (A < B + Bin, unsigned)
//   Overflow     out  1      signed overflow (SUB_OVERFLOW_EN only)
// ---------------------------------------------------------------------------
module serial_borrow_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             InputBorrow,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] DiffOut,
`ifdef SUB_OVERFLOW_EN
  output logic             BorrowOut,
  output logic             Overflow
`else
  output logic             BorrowOut
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic [CNT_W-1:0]   cnt;
  logic               br;
`ifdef SUB_OVERFLOW_EN
  logic               a_msb;
  logic               b_msb;
`endif

  logic               last_c;
  logic               accept_c;
  logic               step_c;
  logic               finish_c;
  logic               d_c;
  logic               br_nxt_c;
  logic [WIDTH-1:0]   res_nxt_c;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    d_c       = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt_c  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_nxt_c = {d_c, res_sr[WIDTH-1:1]};
  end

  assign last_c = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = BUSY;
      BUSY:    if (last_c) state_nxt = DONE;
      DONE:    state_nxt = Start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control decoded from the current state
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      IDLE, DONE: accept_c = Start;
      BUSY: begin
        step_c   = 1'b1;
        finish_c = last_c;
      end
      default: ;
    endcase
  end

  // Shift registers, borrow flop, counter and registered outputs
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      cnt       <= '0;
      br        <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DiffOut   <= '0;
      BorrowOut <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      Overflow  <= 1'b0;
`endif
    end else if (accept_c) begin
      a_sr   <= InputA;
      b_sr   <= InputB;
      res_sr <= '0;
      cnt    <= '0;
      br     <= InputBorrow;
      Busy   <= 1'b1;
      Done   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb  <= InputA[WIDTH-1];
      b_msb  <= InputB[WIDTH-1];
`endif
    end else if (step_c) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt_c;
      br     <= br_nxt_c;
      cnt    <= cnt + CNT_W'(1);
      Done   <= 1'b0;
      if (finish_c) begin
        DiffOut   <= res_nxt_c;
        BorrowOut <= br_nxt_c;
        Busy      <= 1'b0;
        Done      <= 1'b1;
`ifdef SUB_OVERFLOW_EN
        // The final difference bit is the result MSB
        Overflow  <= (a_msb ^ b_msb) & (a_msb ^ d_c);
`endif
      end
    end else begin
      Done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Testbench for serial_borrow_subtractor (WIDTH=4), randomized and directed
// stimulus against an arithmetic reference model.
module tb_serial_borrow_subtractor;

  localparam int unsigned W = 4;

  logic         Clock;
  logic         ResetN;
  logic         Start;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic         InputBorrow;
  logic         Busy;
  logic         Done;
  logic [W-1:0] DiffOut;
  logic         BorrowOut;
`ifdef SUB_OVERFLOW_EN
  logic         Overflow;
`endif

  int total;
  int bad;

  logic [W-1:0] exp_diff;
  logic         exp_bo;
  logic         exp_ov;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .Clock       (Clock),
    .ResetN      (ResetN),
    .Start       (Start),
    .InputA      (InputA),
    .InputB      (InputB),
    .InputBorrow (InputBorrow),
    .Busy        (Busy),
    .Done        (Done),
    .DiffOut     (DiffOut),
`ifdef SUB_OVERFLOW_EN
    .BorrowOut   (BorrowOut),
    .Overflow    (Overflow)
`else
    .BorrowOut   (BorrowOut)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {borrow, diff} = A - B - Bin modulo 2^(W+1)
  function automatic logic [W:0] model_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return (W+1)'(r);
  endfunction

  // Signed overflow: true signed difference outside the W-bit signed range
  function automatic logic model_ov(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic bin);
    int sa;
    int sb;
    int s;
    sa = int'(a) - (a[W-1] ? (1 << W) : 0);
    sb = int'(b) - (b[W-1] ? (1 << W) : 0);
    s  = sa - sb - int'(bin);
    return (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
  endfunction

  function automatic logic ov_now();
`ifdef SUB_OVERFLOW_EN
    return Overflow;
`else
    return exp_ov;
`endif
  endfunction

  // One operation: accept, optional ignored Start mid-busy, completion check
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input int inject);
    logic [W:0] e;
    logic       got;
    int         n;
    e = model_sub(a, b, bin);
    @(negedge Clock);
    Start = 1'b1; InputA = a; InputB = b; InputBorrow = bin;
    @(posedge Clock); #1;
    total++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      bad++;
      $display("FAIL accept a=%0d b=%0d: busy=%b done=%b, want busy=1 done=0", a, b, Busy, Done);
    end
    Start = 1'b0;
    InputA = W'($urandom); InputB = W'($urandom); InputBorrow = 1'($urandom);
    n = 0; got = 1'b0;
    while (!got && n < 12) begin
      if (inject != 0 && n == inject) begin
        Start = 1'b1; InputA = 4'd9; InputB = 4'd1; InputBorrow = 1'b0;
      end
      @(posedge Clock); #1;
      Start = 1'b0;
      n++;
      if (Done === 1'b1) got = 1'b1;
      else begin
        total++;
        if (Busy !== 1'b1 || DiffOut !== exp_diff || BorrowOut !== exp_bo || ov_now() !== exp_ov) begin
          bad++;
          $display("FAIL hold cyc=%0d: busy=%b diff=%0d bo=%b ov=%b, want busy=1 diff=%0d bo=%b ov=%b",
                   n, Busy, DiffOut, BorrowOut, ov_now(), exp_diff, exp_bo, exp_ov);
        end
      end
    end
    total++;
    if (!got || n != W) begin
      bad++;
      $display("FAIL latency a=%0d b=%0d: got=%b cycles=%0d, want done after %0d", a, b, got, n, W);
    end
    exp_diff = e[W-1:0];
    exp_bo   = e[W];
    exp_ov   = model_ov(a, b, bin);
    total++;
    if (DiffOut !== exp_diff || BorrowOut !== exp_bo || Busy !== 1'b0 || ov_now() !== exp_ov) begin
      bad++;
      $display("FAIL result a=%0d b=%0d bin=%b: diff=%0d bo=%b ov=%b busy=%b, want diff=%0d bo=%b ov=%b busy=0",
               a, b, bin, DiffOut, BorrowOut, ov_now(), Busy, exp_diff, exp_bo, exp_ov);
    end
  endtask

  // Idle cycle after completion: Done drops, result held
  task automatic idle_check();
    @(posedge Clock); #1;
    total++;
    if (Done !== 1'b0 || Busy !== 1'b0 || DiffOut !== exp_diff || BorrowOut !== exp_bo) begin
      bad++;
      $display("FAIL idle: done=%b busy=%b diff=%0d bo=%b, want done=0 busy=0 diff=%0d bo=%b",
               Done, Busy, DiffOut, BorrowOut, exp_diff, exp_bo);
    end
  endtask

  task automatic check_zero(input string tag);
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || DiffOut !== '0 || BorrowOut !== 1'b0
`ifdef SUB_OVERFLOW_EN
        || Overflow !== 1'b0
`endif
       ) begin
      bad++;
      $display("FAIL %s: busy=%b done=%b diff=%0d bo=%b, want all 0", tag, Busy, Done, DiffOut, BorrowOut);
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0; Start = 1'b0; InputA = '0; InputB = '0; InputBorrow = 1'b0;
    exp_diff = '0; exp_bo = 1'b0; exp_ov = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_zero("reset");
    @(negedge Clock);
    ResetN = 1'b1;
    @(posedge Clock); #1;
    check_zero("post_reset_idle");
  endtask

  task automatic test_directed();
    run_op(4'd5, 4'd3, 1'b0, 0);   idle_check();
    run_op(4'd3, 4'd5, 1'b0, 0);   idle_check();
    run_op(4'd0, 4'd0, 1'b1, 0);   idle_check();
    run_op(4'd15, 4'd15, 1'b1, 0); idle_check();
    run_op(4'd8, 4'd1, 1'b0, 0);   idle_check();
    run_op(4'd7, 4'd1, 1'b0, 0);   idle_check();
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_op(W'(a), W'(b), 1'(c), 0);
    idle_check();
  endtask

  task automatic test_busy_ignore();
    run_op(4'd5, 4'd3, 1'b0, 1);
    idle_check();
    run_op(4'd12, 4'd6, 1'b1, 2);
    idle_check();
  endtask

  task automatic test_back_to_back();
    logic [W:0] e2;
    logic       got;
    int         n;
    run_op(4'd9, 4'd4, 1'b0, 0);
    // Start held through the Done cycle with the next operands
    run_op(4'd2, 4'd7, 1'b0, 0);
    e2 = model_sub(4'd11, 4'd3, 1'b1);
    @(negedge Clock);
    Start = 1'b1; InputA = 4'd11; InputB = 4'd3; InputBorrow = 1'b1;
    @(posedge Clock); #1;
    total++;
    if (Busy !== 1'b1 || Done !== 1'b0 || DiffOut !== exp_diff) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b done=%b diff=%0d, want busy=1 done=0 diff=%0d",
               Busy, Done, DiffOut, exp_diff);
    end
    Start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 12) begin
      @(posedge Clock); #1;
      n++;
      if (Done === 1'b1) got = 1'b1;
    end
    total++;
    if (!got || n != W || DiffOut !== e2[W-1:0] || BorrowOut !== e2[W]) begin
      bad++;
      $display("FAIL b2b_result: got=%b cycles=%0d diff=%0d bo=%b, want cycles=%0d diff=%0d bo=%b",
               got, n, DiffOut, BorrowOut, W, e2[W-1:0], e2[W]);
    end
    exp_diff = e2[W-1:0]; exp_bo = e2[W]; exp_ov = model_ov(4'd11, 4'd3, 1'b1);
    idle_check();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    run_op(4'd5, 4'd3, 1'b0, 0);
    idle_check();
    @(negedge Clock);
    Start = 1'b1; InputA = 4'd12; InputB = 4'd3; InputBorrow = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check_zero("reset_mid");
    done_seen = 0;
    repeat (3) begin
      @(posedge Clock); #1;
      if (Done !== 1'b0) done_seen++;
    end
    @(negedge Clock);
    ResetN = 1'b1;
    repeat (6) begin
      @(posedge Clock); #1;
      if (Done !== 1'b0 || Busy !== 1'b0) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL reset_no_done: done/busy seen %0d cycles, want 0", done_seen);
    end
    exp_diff = '0; exp_bo = 1'b0; exp_ov = 1'b0;
    run_op(4'd7, 4'd2, 1'b0, 0);
    idle_check();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) idle_check();
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end
    idle_check();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_sweep();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
